uart_rx_os16: RTL and testbench

Asynchronous serial receiver: the receive-side counterpart of the team's baud generator. It recovers 8N1 frames from the `rx_in` line using an internal 16x-oversampling tick derived from the same `HIGH_CLK`/`BAUD_CLK` parameters. It delivers each byte with a one-cycle valid strobe. It sits between the board's UART RX pin and the game-move command parser.

---
 rtl/uart_rx_os16.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16 -- 8N1 UART receiver using an internal 16x oversampling tick.
// Recovers bytes from the asynchronous rx_in line and presents each one on
// data_out together with a single-cycle data_valid strobe. A low stop bit
// raises a single-cycle frame_error and parks the receiver in BREAK until the
// line returns high, so a line held low cannot retrigger reception.
module uart_rx_os16 #(
  parameter int HIGH_CLK = 50_000_000,
  parameter int BAUD_CLK = 115_200
) (
  input  logic       high_clk_in,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  // Oversampling tick divider: one tick every TICK_DIV+1 clocks.
  localparam int TICK_DIV = HIGH_CLK / (16 * BAUD_CLK) - 1;
  localparam int TICK_W   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic [1:0]        sync_q;
  logic              rx_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  state_t            state_q,   state_nxt;
  logic [3:0]        os_cnt_q,  os_cnt_nxt;
  logic [2:0]        bit_idx_q, bit_idx_nxt;
  logic [7:0]        shift_q,   shift_nxt;
  logic [7:0]        data_nxt;
  logic              valid_nxt;
  logic              ferr_nxt;
  logic              busy_nxt;

  // Two-flop synchronizer for the asynchronous serial line.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge high_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;  // reset to the idle level so release is not a start edge
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];

  // Free-running 16x tick divider, held at zero while disabled.
  always_ff @(posedge high_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable || (tick_cnt == TICK_MAX)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = enable && (tick_cnt == TICK_MAX);

  // Next-state and output decode for the receive FSM.
  // NOTE: every variable written here is given a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt   = state_q;
    os_cnt_nxt  = os_cnt_q;
    bit_idx_nxt = bit_idx_q;
    shift_nxt   = shift_q;
    data_nxt    = data_out;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    if (!enable) begin
      // Disabling discards any partial frame silently.
      state_nxt   = ST_IDLE;
      os_cnt_nxt  = '0;
      bit_idx_nxt = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt  = ST_START;
            os_cnt_nxt = '0;
          end
        end

        ST_START: begin
          if (os_cnt_q == 4'd7) begin
            // Mid start bit: a line that is high again was only a glitch.
            if (!rx_s) begin
              state_nxt   = ST_DATA;
              os_cnt_nxt  = '0;
              bit_idx_nxt = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            os_cnt_nxt = os_cnt_q + 4'd1;
          end
        end

        ST_DATA: begin
          // os_cnt wraps 15 -> 0, so each data bit is sampled 16 ticks apart.
          os_cnt_nxt = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            shift_nxt   = {rx_s, shift_q[7:1]};  // LSB arrives first
            bit_idx_nxt = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_nxt  = ST_STOP;
              os_cnt_nxt = '0;
            end
          end
        end

        ST_STOP: begin
          if (os_cnt_q == 4'd15) begin
            if (rx_s) begin
              data_nxt  = shift_q;
              valid_nxt = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = ST_BREAK;
            end
          end else begin
            os_cnt_nxt = os_cnt_q + 4'd1;
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge high_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      os_cnt_q    <= os_cnt_nxt;
      bit_idx_q   <= bit_idx_nxt;
      shift_q     <= shift_nxt;
      data_out    <= data_nxt;
      data_valid  <= valid_nxt;
      frame_error <= ferr_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16 -- self-checking bench for uart_rx_os16.
// A fast instance (tick every clock, 16 clocks per bit) takes directed and
// randomized frames; the expected strobe kind, byte and arrival cycle of each
// frame are derived from the line timing and kept in a queue. A second
// instance at default parameters receives one frame at a 434-clock bit period.
module tb_uart_rx_os16;

  localparam int BIT_CLKS = 16;   // fast instance: 16 ticks, one per clock
  localparam int LAT      = 155;  // line fall -> strobe: 2 sync + 152 + 1
  localparam int BIT_D    = 434;  // default instance bit period in clocks
  localparam int LAT_D_LO = 3 + 152 * 27;   // earliest detect tick + 152 ticks
  localparam int LAT_D_HI = 29 + 152 * 27;  // latest detect tick + 152 ticks

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_error, busy;

  logic       enable_d = 1'b1;
  logic       rx_d     = 1'b1;
  logic [7:0] data_out_d;
  logic       data_valid_d, frame_error_d, busy_d;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] model_last = 8'h00;

  int         d2_cnt  = 0;
  int         d2_fe   = 0;
  int         d2_cyc  = 0;
  logic [7:0] d2_data = 8'h00;
  int         t6_c;

  logic [7:0] r_b;
  bit         r_bad;
  int         r_gap;

  uart_rx_os16 #(.HIGH_CLK(1_600_000), .BAUD_CLK(100_000)) dut (
    .high_clk_in (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .rx_in       (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  uart_rx_os16 dut_d (
    .high_clk_in (clk),
    .reset_n     (reset_n),
    .enable      (enable_d),
    .rx_in       (rx_d),
    .data_out    (data_out_d),
    .data_valid  (data_valid_d),
    .frame_error (frame_error_d),
    .busy        (busy_d)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_d(input logic v, input int n);
    rx_d = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame on the fast line; optionally records the strobe it must cause.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap,
                            input bit expect_ev);
    ev_t e;
    if (expect_ev) begin
      e.is_err = !stop_ok;
      e.data   = stop_ok ? b : model_last;
      e.due    = cyc + LAT;
      exp_q.push_back(e);
      if (stop_ok) model_last = b;
    end
    drive(1'b0, BIT_CLKS);
    for (int k = 0; k < 8; k++) drive(b[k], BIT_CLKS);
    drive(stop_ok, BIT_CLKS);
    if (gap > 0) drive(1'b1, gap);
  endtask

  task automatic glitch(input int len);
    drive(1'b0, len);
    drive(1'b1, 20);
  endtask

  // Match every strobe of the fast instance against the expected-event queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_valid || frame_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_error}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_is_error", {31'd0, frame_error}, {31'd0, mon_e.is_err});
          check("pulse_is_valid", {31'd0, data_valid}, {31'd0, !mon_e.is_err});
          check("pulse_data", {24'd0, data_out}, {24'd0, mon_e.data});
          check("pulse_cycle", cyc, mon_e.due);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        check("missing_pulse_due", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // Record strobes of the default-parameter instance.
  always @(negedge clk) begin
    if (data_valid_d) begin
      d2_cnt++;
      d2_cyc  = cyc;
      d2_data = data_out_d;
    end
    if (frame_error_d) d2_fe++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_ferr", {31'd0, frame_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Good frame with exact latency.
    fork
      send_frame(8'hA5, 1'b1, 20, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check("t1_busy_mid_frame", {31'd0, busy}, 32'd1);
      end
    join

    // Back-to-back frames, zero idle gap.
    send_frame(8'h00, 1'b1, 0, 1'b1);
    send_frame(8'hFF, 1'b1, 20, 1'b1);

    // Glitch rejection.
    drive(1'b0, 4);
    check("t3_busy_in_glitch", {31'd0, busy}, 32'd1);
    drive(1'b1, 20);
    check("t3_busy_after_glitch", {31'd0, busy}, 32'd0);
    check("t3_data_kept", {24'd0, data_out}, {24'd0, model_last});

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, 0, 1'b1);
    drive(1'b0, 250);
    check("t4_busy_in_break", {31'd0, busy}, 32'd1);
    drive(1'b0, 250);
    drive(1'b1, 40);
    check("t4_busy_after_break", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1, 40, 1'b1);

    // Enable dropped during bit 4 of a frame.
    fork
      send_frame(8'h81, 1'b1, 40, 1'b0);
      begin
        repeat (90) @(negedge clk);
        check("t5_busy_before_drop", {31'd0, busy}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_busy_after_drop", {31'd0, busy}, 32'd0);
      end
    join
    check("t5_data_kept", {24'd0, data_out}, {24'd0, model_last});
    enable = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, 40, 1'b1);

    // Reset asserted mid-frame, released on an idle line.
    fork
      send_frame(8'h81, 1'b1, 40, 1'b0);
      begin
        repeat (90) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t5_reset_data", {24'd0, data_out}, 32'd0);
        check("t5_reset_busy", {31'd0, busy}, 32'd0);
      end
    join
    model_last = 8'h00;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_data_after_reset", {24'd0, data_out}, 32'd0);

    // Randomized frames, gaps, bad stops and glitches.
    for (int i = 0; i < 24; i++) begin
      r_b   = 8'($urandom);
      r_bad = ($urandom_range(0, 6) == 0);
      r_gap = r_bad ? int'($urandom_range(1, 30)) : int'($urandom_range(0, 30));
      if ($urandom_range(0, 5) == 0) glitch(int'($urandom_range(1, 6)));
      send_frame(r_b, !r_bad, r_gap, 1'b1);
    end
    drive(1'b1, 200);

    // Default parameters: 0x5A at a 434-clock bit period.
    t6_c = cyc;
    drive_d(1'b0, BIT_D);
    for (int k = 0; k < 8; k++) drive_d(r_b[0] ^ r_b[0] ^ (8'h5A >> k) & 1'b1, BIT_D);
    drive_d(1'b1, BIT_D);
    drive_d(1'b1, 300);
    check("t6_valid_count", d2_cnt, 32'd1);
    check("t6_data", {24'd0, d2_data}, 32'h5A);
    check("t6_frame_errors", d2_fe, 32'd0);
    check("t6_latency_window",
          {31'd0, ((d2_cyc - t6_c) >= LAT_D_LO) && ((d2_cyc - t6_c) <= LAT_D_HI)}, 32'd1);

    check("events_outstanding", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
